// File: rtl/batch_uart_transmitter.sv
// Purpose: drains a batch memory (addresses 0..BATCH_SIZE-1) word by word onto a UART TX line, LSB first, 1 start / 1 stop bit.
// Latency: start sampled at edge k -> mem_en after k, start bit after k+2; each word costs frame + 2 cycles (FETCH, LOAD).
// Backpressure: none; start is ignored while busy. Optional even parity bit when UART_TX_PARITY_EN is defined.
module batch_uart_transmitter #(
    parameter int BATCH_SIZE     = 1000,
    parameter int MEM_ADDR_WIDTH = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1,
    parameter int DATA_WIDTH     = 8,
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int CLKS_PER_BIT   = CLK_FREQ / BAUD_RATE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    output logic                      tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0]          CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]          BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_LAST = MEM_ADDR_WIDTH'(BATCH_SIZE - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
`endif

    state_t                 state;
    logic [CNT_W-1:0]       clk_cnt;   // clocks elapsed within the current bit period
    logic [BIT_W-1:0]       bit_idx;   // data bit currently on the line
    logic [DATA_WIDTH-1:0]  shreg;     // bits still waiting to be sent, next one in [0]
`ifdef UART_TX_PARITY_EN
    logic                   parity_bit;
`endif

    wire period_end = (clk_cnt == CNT_LAST);

    // Batch sequencer and bit serialiser; every output is a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (start) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        mem_en   <= 1'b1;
                        mem_addr <= '0;
                    end
                end

                // Read request was presented during this cycle; data returns next cycle.
                FETCH: begin
                    mem_en <= 1'b0;
                    state  <= LOAD;
                end

                // The only cycle where mem_data is looked at.
                LOAD: begin
                    shreg   <= mem_data;
`ifdef UART_TX_PARITY_EN
                    parity_bit <= ^mem_data;
`endif
                    tx      <= 1'b0;
                    clk_cnt <= '0;
                    state   <= START;
                end

                START: begin
                    if (period_end) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (period_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (period_end) begin
                        clk_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif

                // End of stop bit: either finish the batch or fetch the next word.
                STOP: begin
                    if (period_end) begin
                        clk_cnt <= '0;
                        if (mem_addr == ADDR_LAST) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            mem_addr <= '0;
                        end else begin
                            state    <= FETCH;
                            mem_en   <= 1'b1;
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
